wb_regfile: RTL and testbench

Writeback-stage consumer of the MEM/WB pipeline register: selects the writeback value (load data or ALU result), commits it to a 32-entry integer register file on the clock edge, and serves the decode stage's two combinational read ports. x0 is hardwired to zero. A retired-write counter supports performance and debug observation. Sits between the MEM/WB register outputs and the ID stage operand fetch.

---
 rtl/wb_regfile.sv | 75 +++++++
 tb/tb_wb_regfile.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: writeback select, 32 x XLEN integer register file, commit counter.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-before-read on read ports.
module wb_regfile #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             regwrite_wb,
  input  logic             memtoreg_wb,
  input  logic [4:0]       rd_wb,
  input  logic [XLEN-1:0]  readdata_wb,
  input  logic [XLEN-1:0]  alu_result_wb,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_commit,
  output logic [CNT_W-1:0] commit_count
);

  logic [XLEN-1:0] regs [32];
  logic            wr_en;

  assign wb_data = memtoreg_wb ? readdata_wb
                               : alu_result_wb;
  assign wr_en = regwrite_wb && (rd_wb != 5'd0);

  // Register array; x0 is cleared on reset and never written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[rd_wb] <= wb_data;
    end
  end

  // Commit pulse and wrapping retired-write counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_commit    <= 1'b0;
      commit_count <= '0;
    end else begin
      wb_commit <= wr_en;
      if (wr_en) begin
        commit_count <= commit_count + 1'b1;
      end
    end
  end

  // Combinational read ports; x0 always reads zero.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != 5'd0) begin
      rs1_data = regs[rs1_addr];
    end
    if (rs2_addr != 5'd0) begin
      rs2_data = regs[rs2_addr];
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (rs1_addr == rd_wb)) begin
      rs1_data = wb_data;
    end
    if (wr_en && (rs2_addr == rd_wb)) begin
      rs2_data = wb_data;
    end
`else
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile.
// Second instance with CNT_W=4 covers counter wrap.
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic        regwrite_wb;
  logic        memtoreg_wb;
  logic [4:0]  rd_wb;
  logic [63:0] readdata_wb;
  logic [63:0] alu_result_wb;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic [63:0] wb_data;
  logic        wb_commit;
  logic [31:0] commit_count;
  logic [63:0] s_rs1_data;
  logic [63:0] s_rs2_data;
  logic [63:0] s_wb_data;
  logic        s_wb_commit;
  logic [3:0]  s_commit_count;

  int checks;
  int errors;

  wb_regfile #(.XLEN(64), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .regwrite_wb(regwrite_wb),
    .memtoreg_wb(memtoreg_wb),
    .rd_wb(rd_wb),
    .readdata_wb(readdata_wb),
    .alu_result_wb(alu_result_wb),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_data(wb_data),
    .wb_commit(wb_commit),
    .commit_count(commit_count)
  );

  wb_regfile #(.XLEN(64), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .regwrite_wb(regwrite_wb),
    .memtoreg_wb(memtoreg_wb),
    .rd_wb(rd_wb),
    .readdata_wb(readdata_wb),
    .alu_result_wb(alu_result_wb),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(s_rs1_data), .rs2_data(s_rs2_data),
    .wb_data(s_wb_data),
    .wb_commit(s_wb_commit),
    .commit_count(s_commit_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_write(input logic [4:0] rd,
                          input logic mtr,
                          input logic [63:0] rdat,
                          input logic [63:0] alu);
    regwrite_wb   = 1'b1;
    memtoreg_wb   = mtr;
    rd_wb         = rd;
    readdata_wb   = rdat;
    alu_result_wb = alu;
    @(posedge clk);
    #1;
    regwrite_wb = 1'b0;
  endtask

  task automatic idle_cycle();
    regwrite_wb = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      checks++;
      if (rs1_data !== 64'd0 || rs2_data !== 64'd0) begin
        errors++;
        $display("FAIL reset_read idx=%0d rs1=%h rs2=%h want 0",
                 i, rs1_data, rs2_data);
      end
    end
    checks++;
    if (commit_count !== 32'd0 || wb_commit !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl cnt=%0d commit=%b want 0/0",
               commit_count, wb_commit);
    end
    memtoreg_wb = 1'b0;
    alu_result_wb = 64'h0BAD;
    #1;
    checks++;
    if (wb_data !== 64'h0BAD) begin
      errors++;
      $display("FAIL reset_wbdata got=%h want 0bad", wb_data);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_select_mux();
    memtoreg_wb = 1'b1;
    readdata_wb = 64'hDEAD_BEEF;
    alu_result_wb = 64'h1234;
    #1;
    checks++;
    if (wb_data !== 64'hDEAD_BEEF) begin
      errors++;
      $display("FAIL mux_load got=%h want deadbeef", wb_data);
    end
    do_write(5'd5, 1'b1, 64'hDEAD_BEEF, 64'h1234);
    checks++;
    if (wb_commit !== 1'b1 || commit_count !== 32'd1) begin
      errors++;
      $display("FAIL mux_commit1 commit=%b cnt=%0d want 1/1",
               wb_commit, commit_count);
    end
    do_write(5'd6, 1'b0, 64'hDEAD_BEEF, 64'h1234);
    rs1_addr = 5'd5;
    rs2_addr = 5'd6;
    #1;
    checks++;
    if (rs1_data !== 64'hDEAD_BEEF) begin
      errors++;
      $display("FAIL mux_x5 got=%h want deadbeef", rs1_data);
    end
    checks++;
    if (rs2_data !== 64'h1234) begin
      errors++;
      $display("FAIL mux_x6 got=%h want 1234", rs2_data);
    end
    checks++;
    if (commit_count !== 32'd2) begin
      errors++;
      $display("FAIL mux_count got=%0d want 2", commit_count);
    end
    idle_cycle();
    checks++;
    if (wb_commit !== 1'b0 || commit_count !== 32'd2) begin
      errors++;
      $display("FAIL idle_hold commit=%b cnt=%0d want 0/2",
               wb_commit, commit_count);
    end
    rs1_addr = 5'd6;
    rs2_addr = 5'd6;
    #1;
    checks++;
    if (rs1_data !== rs2_data || rs1_data !== 64'h1234) begin
      errors++;
      $display("FAIL same_idx rs1=%h rs2=%h want 1234",
               rs1_data, rs2_data);
    end
  endtask

  task automatic test_x0_guard();
    do_write(5'd0, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    #1;
    checks++;
    if (rs1_data !== 64'd0 || rs2_data !== 64'd0) begin
      errors++;
      $display("FAIL x0_read rs1=%h rs2=%h want 0",
               rs1_data, rs2_data);
    end
    checks++;
    if (commit_count !== 32'd2 || wb_commit !== 1'b0) begin
      errors++;
      $display("FAIL x0_ctrl cnt=%0d commit=%b want 2/0",
               commit_count, wb_commit);
    end
  endtask

  task automatic test_bypass();
    logic [63:0] exp_same;
    do_write(5'd7, 1'b0, 64'd0, 64'h55);
`ifdef REGFILE_BYPASS_EN
    exp_same = 64'hAA;
`else
    exp_same = 64'h55;
`endif
    regwrite_wb = 1'b1;
    memtoreg_wb = 1'b0;
    rd_wb = 5'd7;
    alu_result_wb = 64'hAA;
    rs1_addr = 5'd7;
    rs2_addr = 5'd6;
    #1;
    checks++;
    if (rs1_data !== exp_same) begin
      errors++;
      $display("FAIL bypass_same got=%h want %h",
               rs1_data, exp_same);
    end
    checks++;
    if (rs2_data !== 64'h1234) begin
      errors++;
      $display("FAIL bypass_other got=%h want 1234", rs2_data);
    end
    @(posedge clk);
    #1;
    regwrite_wb = 1'b0;
    checks++;
    if (rs1_data !== 64'hAA) begin
      errors++;
      $display("FAIL bypass_next got=%h want aa", rs1_data);
    end
    regwrite_wb = 1'b1;
    rd_wb = 5'd0;
    alu_result_wb = 64'hFFFF_FFFF_FFFF_FFFF;
    rs1_addr = 5'd0;
    #1;
    checks++;
    if (rs1_data !== 64'd0) begin
      errors++;
      $display("FAIL bypass_x0 got=%h want 0", rs1_data);
    end
    @(posedge clk);
    #1;
    regwrite_wb = 1'b0;
    checks++;
    if (commit_count !== 32'd4) begin
      errors++;
      $display("FAIL bypass_count got=%0d want 4", commit_count);
    end
  endtask

  task automatic test_back_to_back();
    do_write(5'd9, 1'b0, 64'd0, 64'h11);
    do_write(5'd9, 1'b1, 64'h22, 64'd0);
    rs1_addr = 5'd9;
    #1;
    checks++;
    if (rs1_data !== 64'h22) begin
      errors++;
      $display("FAIL b2b_value got=%h want 22", rs1_data);
    end
    checks++;
    if (commit_count !== 32'd6 || wb_commit !== 1'b1) begin
      errors++;
      $display("FAIL b2b_count cnt=%0d commit=%b want 6/1",
               commit_count, wb_commit);
    end
  endtask

  task automatic test_reset_mid_write();
    do_write(5'd3, 1'b0, 64'd0, 64'h99);
    rs1_addr = 5'd3;
    #1;
    checks++;
    if (rs1_data !== 64'h99) begin
      errors++;
      $display("FAIL rmid_pre got=%h want 99", rs1_data);
    end
    regwrite_wb = 1'b1;
    memtoreg_wb = 1'b0;
    rd_wb = 5'd3;
    alu_result_wb = 64'h77;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rs1_data !== 64'd0 || commit_count !== 32'd0) begin
      errors++;
      $display("FAIL rmid_reset x3=%h cnt=%0d want 0/0",
               rs1_data, commit_count);
    end
    checks++;
    if (wb_commit !== 1'b0) begin
      errors++;
      $display("FAIL rmid_commit got=%b want 0", wb_commit);
    end
    regwrite_wb = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle_cycle();
    checks++;
    if (rs1_data !== 64'd0 || commit_count !== 32'd0) begin
      errors++;
      $display("FAIL rmid_after x3=%h cnt=%0d want 0/0",
               rs1_data, commit_count);
    end
  endtask

  task automatic test_counter_wrap();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 17; i++) begin
      do_write(5'((i % 31) + 1), 1'b0, 64'd0, 64'(i));
      if (s_wb_commit === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 17) begin
      errors++;
      $display("FAIL wrap_pulses got=%0d want 17", pulses);
    end
    checks++;
    if (s_commit_count !== 4'd1) begin
      errors++;
      $display("FAIL wrap_cnt4 got=%0d want 1", s_commit_count);
    end
    checks++;
    if (commit_count !== 32'd17) begin
      errors++;
      $display("FAIL wrap_cnt32 got=%0d want 17", commit_count);
    end
    rs1_addr = 5'd17;
    rs2_addr = 5'd1;
    #1;
    checks++;
    if (rs1_data !== 64'd16 || s_rs2_data !== 64'd0) begin
      errors++;
      $display("FAIL wrap_data x17=%h x1=%h want 10/0",
               rs1_data, s_rs2_data);
    end
    idle_cycle();
    checks++;
    if (s_wb_commit !== 1'b0 || s_commit_count !== 4'd1) begin
      errors++;
      $display("FAIL wrap_idle commit=%b cnt=%0d want 0/1",
               s_wb_commit, s_commit_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    regwrite_wb = 1'b0;
    memtoreg_wb = 1'b0;
    rd_wb = 5'd0;
    readdata_wb = 64'd0;
    alu_result_wb = 64'd0;
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    test_reset();
    test_select_mux();
    test_x0_guard();
    test_bypass();
    test_back_to_back();
    test_reset_mid_write();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
